// File: rtl/ser_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
package ser_pkg;

   // Encoding 2'd3 is unused; the FSM recovers from it to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ser_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element the serial sequencer uses.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic cin,
   output logic Y,
   output logic cout
);

   assign Y    = A ^ B ^ cin;
   assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder shared across WIDTH bits, LSB first,
// with a start/busy/done handshake and a registered result.
module serial_add_ctrl
   import ser_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   ser_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             fa_y, fa_cout;

   full_adder u_fa (
      .A    (a_sr_q[0]),
      .B    (b_sr_q[0]),
      .cin  (carry_q),
      .Y    (fa_y),
      .cout (fa_cout)
   );

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Each result bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            acc_d   = {fa_y, acc_q[WIDTH-1:1]};
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               sum_d   = {fa_y, acc_q[WIDTH-1:1]};
               cout_d  = fa_cout;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: driver pushes a+b+cin expectations, a monitor
// pops and compares on every done pulse.
module tb_serial_add_ctrl;
   import ser_pkg::*;

   localparam int W = 4;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [W:0] exp_q[$];
   int         acc_cyc_q[$];
   logic [W:0] last_res = '0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference: {cout,sum} = a + b + cin in W+1 bits
   function automatic logic [W:0] ref_add(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                          input logic ic);
      return (W+1)'(ia) + (W+1)'(ib) + (W+1)'(ic);
   endfunction

   // monitor: every done pulse must match the oldest expectation and its latency
   always @(negedge clk) begin : monitor
      logic [W:0] e;
      int         c0;
      if (rst_n && done) begin
         chk("done_expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            c0 = acc_cyc_q.pop_front();
            chk("result", int'({cout, sum}), int'(e));
            chk("latency", cyc - c0, W);
         end
      end
   end

   // driver: one addition, called and returning at a negedge with the DUT idle
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input bit poke);
      logic [W:0] res;
      res   = ref_add(ia, ib, ic);
      a     = ia;
      b     = ib;
      cin   = ic;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_q.push_back(res);
      acc_cyc_q.push_back(cyc);
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         chk("busy_run", int'(busy), 1);
         chk("done_run", int'(done), 0);
         chk("hold_run", int'({cout, sum}), int'(last_res));
         if (poke && k == 2) begin
            a = W'(9); b = W'(9); start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
      @(negedge clk);
      chk("busy_at_done", int'(busy), 0);
      chk("done_pulse", int'(done), 1);
      last_res = res;
      if (poke) begin
         a = W'(9); b = W'(9); start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
      end
      @(negedge clk);
      chk("done_clear", int'(done), 0);
      chk("busy_idle", int'(busy), 0);
   endtask

   initial begin
      int c0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sum", int'(sum), 0);
      chk("rst_cout", int'(cout), 0);
      chk("rst_state", int'(dut.state_q), int'(ST_IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      issue(W'(5), W'(6), 1'b0, 1'b0);
      issue(W'(15), W'(1), 1'b0, 1'b0);
      issue(W'(7), W'(8), 1'b1, 1'b0);
      issue(W'(3), W'(4), 1'b0, 1'b1);

      // abort mid-RUN: no done, outputs cleared at once
      a = W'(12); b = W'(1); cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_sum", int'(sum), 0);
      chk("abort_cout", int'(cout), 0);
      chk("abort_state", int'(dut.state_q), int'(ST_IDLE));
      last_res = '0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int k = 0; k < W + 3; k++) begin
         @(negedge clk);
         chk("no_done_after_abort", int'(done), 0);
      end
      issue(W'(2), W'(2), 1'b0, 1'b0);

      // start held high: back-to-back every W+2 cycles
      a = W'(1); b = W'(1); cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(ref_add(W'(1), W'(1), 1'b0));
         acc_cyc_q.push_back(c0 + i * (W + 2));
      end
      repeat (2 * (W + 2)) @(posedge clk);
      #1 start = 1'b0;
      last_res = ref_add(W'(1), W'(1), 1'b0);
      repeat (W + 2) @(negedge clk);
      chk("b2b_drained", exp_q.size(), 0);

      for (int ia = 0; ia < (1 << W); ia++)
         for (int ib = 0; ib < (1 << W); ib++)
            for (int ic = 0; ic < 2; ic++)
               issue(W'(ia), W'(ib), 1'(ic), 1'b0);

      repeat (40)
         issue(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. It time-shares a single `full_adder` instance across the WIDTH bits of two operands: one bit per clock, LSB first, with the carry held in a flop between bits. It sits between board switches and LEDs as the clocked successor to the combinational ripple adder, and trades area for latency. It uses a start/busy/done handshake so a pushbutton or upstream FSM can launch additions.

Parameters:
- WIDTH, 4, operand/sum width in bits; legal range 2..16.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request an addition; sampled only in IDLE.
- a, input, WIDTH, operand A; captured on the accepting edge.
- b, input, WIDTH, operand B; captured on the accepting edge.
- cin, input, 1, carry-in; captured on the accepting edge.
- busy, output, 1, high while bits are being processed (RUN).
- done, output, 1, one-cycle pulse: sum/cout just updated.
- sum, output, WIDTH, registered result; holds the last completed result.
- cout, output, 1, registered carry-out of the last completed result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; operand shift registers, carry flop and bit counter cleared.
- Deassertion of reset is not required to be synchronised inside this block.
- FSM states:
  - IDLE: if start=1, latch a, b into shift regs, carry<=cin, cnt<=0, go to RUN. Otherwise stay in IDLE.
  - RUN: full_adder(A=a_sr[0], B=b_sr[0], cin=carry).
    - Its Y shifts into acc MSB. a_sr and b_sr shift right. carry<=cout. cnt<=cnt+1.
    - When cnt==WIDTH-1: sum<=final acc (including this bit), cout<=adder cout, go to DONE.
  - DONE: single cycle, then IDLE unconditionally.
- busy is high exactly while state==RUN. done is high exactly while state==DONE.
- Latency: start sampled at edge E0. Bits are processed at edges E1..E_WIDTH. done=1 and sum valid after E_WIDTH. done returns to 0 after E_WIDTH+1. Next start can be accepted at E_WIDTH+2.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- sum/cout change only on the DONE transition; during RUN they hold the previous result.
- start while RUN or DONE: ignored, not queued. Operand changes after the accepting edge have no effect.
- start held high continuously: back-to-back operations, one every WIDTH+2 cycles.
- Reset mid-RUN: operation aborted, outputs cleared to 0, no done pulse.
- cnt width: $clog2(WIDTH); no wrap-around occurs because the FSM leaves RUN at WIDTH-1.

Decomposition:
- Shared package ser_pkg: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 unused; recovers to IDLE).
- One sub-module: the existing `full_adder` (ports A, B, cin, Y, cout), instantiated exactly once. No other arithmetic in this block.

Test Plan:
- WIDTH=4, a=5, b=6, cin=0, start 1 cycle -> busy high 4 cycles, done pulse after 4th bit edge, sum=11, cout=0.
- a=15, b=1, cin=0 -> sum=0, cout=1; a=7, b=8, cin=1 -> sum=0, cout=1.
- Start a=3, b=4; pulse start again with a=9, b=9 during RUN and during DONE -> both ignored, sum=7; prior sum held during RUN.
- Reset asserted at 2nd RUN cycle -> busy, done, sum, cout = 0 immediately (async), state IDLE, no done pulse. A fresh start with a=2, b=2 gives sum=4.
- start held high with a=1, b=1 -> done pulses every 6 cycles (WIDTH+2), sum=2 each time.
- Exhaustive WIDTH=4 sweep of a, b, cin (512 cases) against the a+b+cin model -> zero mismatches.
